// File: rtl/pmt_bin_counter.sv
// Multi-channel PMT photon counter: synchronised edge detection, saturating
// per-channel counts over consecutive time bins, results handed off via valid/ready.
module pmt_bin_counter #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int LEN_W       = 24,
  parameter int IDX_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       pmt_in,
  input  logic                      run,
  input  logic [LEN_W-1:0]          bin_len,
  input  logic [IDX_W-1:0]          num_bins,
  output logic [CHANNELS*CNT_W-1:0] out_counts,
  output logic [CHANNELS-1:0]       out_sat,
  output logic [IDX_W-1:0]          out_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      lost,
  output logic                      busy,
  output logic                      done
);

  // state  | meaning
  // IDLE   | waiting for run (re-armed only after run has been low)
  // COUNT  | counting edges, closing a bin every len_r cycles
  // DONE   | one-cycle done pulse after the final bin
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] pmt_edge;

  logic [CNT_W-1:0]          cnt     [CHANNELS];
  logic [CNT_W-1:0]          cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0]       sat, sat_nxt;
  logic [CHANNELS*CNT_W-1:0] cnt_flat_nxt;

  logic [LEN_W-1:0] len_r, cyc;
  logic [IDX_W-1:0] nb_r, bin_idx;
  logic             run_ok;
  logic             start, bin_end, last_bin, new_res;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pmt_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pmt_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Count including this cycle's edge, so an edge in the closing cycle lands in that bin.
  always_comb begin
    sat_nxt      = sat;
    cnt_flat_nxt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_nxt[k] = cnt[k];
      if (pmt_edge[k]) begin
        if (&cnt[k]) sat_nxt[k] = 1'b1;
        else         cnt_nxt[k] = cnt[k] + CNT_W'(1);
      end
      cnt_flat_nxt[k*CNT_W +: CNT_W] = cnt_nxt[k];
    end
  end

  assign bin_end  = (cyc == len_r - LEN_W'(1));
  assign last_bin = (nb_r != '0) && (bin_idx == nb_r - IDX_W'(1));
  assign new_res  = (state == S_COUNT) && run && bin_end;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && run_ok) begin
          state_nxt = S_COUNT;
          start     = 1'b1;
        end
      end
      S_COUNT: begin
        if (!run)                     state_nxt = S_IDLE;
        else if (bin_end && last_bin) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_COUNT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_r      <= '0;
      nb_r       <= '0;
      cyc        <= '0;
      bin_idx    <= '0;
      sat        <= '0;
      for (int k = 0; k < CHANNELS; k++) cnt[k] <= '0;
      run_ok     <= 1'b1;
      out_counts <= '0;
      out_sat    <= '0;
      out_bin    <= '0;
      out_valid  <= 1'b0;
      lost       <= 1'b0;
    end else begin
      // A run that ends in DONE must see run low before another can start.
      if (!run)                run_ok <= 1'b1;
      else if (state == S_DONE) run_ok <= 1'b0;

      if (start) begin
        len_r   <= (bin_len == '0) ? LEN_W'(1) : bin_len;
        nb_r    <= num_bins;
        cyc     <= '0;
        bin_idx <= '0;
        sat     <= '0;
        for (int k = 0; k < CHANNELS; k++) cnt[k] <= '0;
        lost    <= 1'b0;
      end else if (state == S_COUNT) begin
        if (new_res) begin
          cyc     <= '0;
          bin_idx <= bin_idx + IDX_W'(1);
          sat     <= '0;
          for (int k = 0; k < CHANNELS; k++) cnt[k] <= '0;
        end else begin
          cyc <= cyc + LEN_W'(1);
          sat <= sat_nxt;
          for (int k = 0; k < CHANNELS; k++) cnt[k] <= cnt_nxt[k];
        end
      end

      if (new_res) begin
        out_counts <= cnt_flat_nxt;
        out_sat    <= sat_nxt;
        out_bin    <= bin_idx;
        out_valid  <= 1'b1;
        if (out_valid && !out_ready) lost <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
